// File: rtl/periph_receiver.sv
// Peripheral end of the send/ack four-phase handshake: synchronizes send, buffers
// dado in a small FIFO, and exposes the words on a valid/ready port with status.
module periph_receiver #(
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk2,
    input  logic                     rst,
    input  logic                     send,
    input  logic [DATA_W-1:0]        dado,
    output logic                     ack,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               rx_count,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_ACK
    } state_t;

    state_t                state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  send_s;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  full, push, pop, set_err;

    // send is asynchronous to clk2; only the last synchronizer stage is ever used.
    always_ff @(posedge clk2) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], send};
    end

    assign send_s = sync_q[SYNC_STAGES-1];
    assign full   = (count_q == CW'(DEPTH));
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q <= S_IDLE;
            ack     <= 1'b0;
        end else begin
            state_q <= state_d;
            ack     <= (state_d == S_ACK);
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        set_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send_s) begin
                    if (!full) begin
                        push    = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!send_s) begin
                    set_err = 1'b1;
                    state_d = S_IDLE;
                end else if (!full) begin
                    push    = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!send_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the buffer is small and its head is visible on out_data, so it is cleared on reset.
    always_ff @(posedge clk2) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dado;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            count_q   <= '0;
            rx_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push)    rx_count  <= rx_count + 8'd1;
            if (set_err) proto_err <= 1'b1;
        end
    end

    assign out_data   = mem[rd_ptr];
    assign out_valid  = (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_periph_receiver.sv
// Bench for periph_receiver: directed handshake scenarios plus randomized traffic
// compared cycle by cycle against a queue-based model of the receiver.
module tb_periph_receiver;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
    localparam int SS     = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk2 = 1'b0;
    logic              rst;
    logic              send;
    logic [DATA_W-1:0] dado;
    logic              ack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     fifo_count;
    logic [7:0]        rx_count;
    logic              proto_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: handshake-level view of the receiver.
    logic [DATA_W-1:0] m_q[$];
    bit                hist[$];
    int                m_rx;
    bit                m_ack, m_hold, m_err;

    periph_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk2(clk2), .rst(rst), .send(send), .dado(dado), .ack(ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .rx_count(rx_count), .proto_err(proto_err)
    );

    always #5 clk2 = ~clk2;

    task automatic model_reset();
        m_q.delete();
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(1'b0);
        m_rx = 0; m_ack = 0; m_hold = 0; m_err = 0;
    endtask

    // One clk2 edge: the model sees the same inputs as the DUT, then outputs settle.
    task automatic step();
        bit s, do_pop;
        int pre;
        @(posedge clk2);
        if (rst) begin
            model_reset();
        end else begin
            s = hist.pop_front();
            hist.push_back(send);
            pre    = m_q.size();
            do_pop = (pre > 0) && out_ready;
            if (!m_ack) begin
                if (s) begin
                    if (pre < DEPTH) begin
                        m_q.push_back(dado);
                        m_rx   = (m_rx + 1) % 256;
                        m_ack  = 1;
                        m_hold = 0;
                    end else begin
                        m_hold = 1;
                    end
                end else if (m_hold) begin
                    m_err  = 1;
                    m_hold = 0;
                end
            end else if (!s) begin
                m_ack = 0;
            end
            if (do_pop) void'(m_q.pop_front());
        end
        #1;
    endtask

    task automatic xfer(input logic [DATA_W-1:0] w);
        int t;
        dado = w; send = 1'b1; t = 0;
        while (ack !== 1'b1 && t < 30) begin step(); t++; end
        vectors++;
        if (ack !== 1'b1) begin
            $display("FAIL xfer_ack_rise: ack=%b want 1 (word %0d)", ack, w); miscompares++;
        end
        send = 1'b0; t = 0;
        while (ack !== 1'b0 && t < 30) begin step(); t++; end
        vectors++;
        if (ack !== 1'b0) begin
            $display("FAIL xfer_ack_fall: ack=%b want 0", ack); miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; send = 1'b0; dado = '0; out_ready = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b0;
        step();
        vectors += 6;
        if (ack !== 1'b0)       begin $display("FAIL reset_ack: %b want 0", ack); miscompares++; end
        if (out_valid !== 1'b0) begin $display("FAIL reset_valid: %b want 0", out_valid); miscompares++; end
        if (out_data !== '0)    begin $display("FAIL reset_data: %0d want 0", out_data); miscompares++; end
        if (fifo_count !== '0)  begin $display("FAIL reset_count: %0d want 0", fifo_count); miscompares++; end
        if (rx_count !== 8'd0)  begin $display("FAIL reset_rx: %0d want 0", rx_count); miscompares++; end
        if (proto_err !== 1'b0) begin $display("FAIL reset_err: %b want 0", proto_err); miscompares++; end
    endtask

    task automatic test_single();
        dado = 2'b10; send = 1'b1;
        step(); step();
        vectors++;
        if (ack !== 1'b0) begin $display("FAIL single_early_ack: %b want 0", ack); miscompares++; end
        step();
        vectors += 5;
        if (ack !== 1'b1)       begin $display("FAIL single_ack: %b want 1", ack); miscompares++; end
        if (out_valid !== 1'b1) begin $display("FAIL single_valid: %b want 1", out_valid); miscompares++; end
        if (out_data !== 2'b10) begin $display("FAIL single_data: %0d want 2", out_data); miscompares++; end
        if (fifo_count !== 3'd1) begin $display("FAIL single_count: %0d want 1", fifo_count); miscompares++; end
        if (rx_count !== 8'd1)  begin $display("FAIL single_rx: %0d want 1", rx_count); miscompares++; end
        send = 1'b0;
        step(); step();
        vectors++;
        if (ack !== 1'b1) begin $display("FAIL single_ack_hold: %b want 1", ack); miscompares++; end
        step();
        vectors++;
        if (ack !== 1'b0) begin $display("FAIL single_ack_release: %b want 0", ack); miscompares++; end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        vectors++;
        if (fifo_count !== 3'd0) begin $display("FAIL single_drain: %0d want 0", fifo_count); miscompares++; end
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0;
        xfer(2'd1); xfer(2'd2); xfer(2'd3); xfer(2'd0);
        vectors += 2;
        if (fifo_count !== 3'd4) begin $display("FAIL fill_count: %0d want 4", fifo_count); miscompares++; end
        if (out_data !== 2'd1)   begin $display("FAIL fill_head: %0d want 1", out_data); miscompares++; end
        dado = 2'd3; send = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (ack !== 1'b0) begin $display("FAIL stall_ack: %b want 0 at cycle %0d", ack, i); miscompares++; end
        end
        vectors++;
        if (fifo_count !== 3'd4) begin $display("FAIL stall_count: %0d want 4", fifo_count); miscompares++; end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        vectors += 3;
        if (fifo_count !== 3'd3) begin $display("FAIL stall_pop_count: %0d want 3", fifo_count); miscompares++; end
        if (out_data !== 2'd2)   begin $display("FAIL stall_pop_head: %0d want 2", out_data); miscompares++; end
        if (ack !== 1'b0)        begin $display("FAIL stall_pop_ack: %b want 0", ack); miscompares++; end
        step();
        vectors += 4;
        if (ack !== 1'b1)        begin $display("FAIL unstall_ack: %b want 1", ack); miscompares++; end
        if (fifo_count !== 3'd4) begin $display("FAIL unstall_count: %0d want 4", fifo_count); miscompares++; end
        if (out_data !== 2'd2)   begin $display("FAIL unstall_head: %0d want 2", out_data); miscompares++; end
        if (rx_count !== 8'd6)   begin $display("FAIL unstall_rx: %0d want 6", rx_count); miscompares++; end
        send = 1'b0;
        for (int i = 0; i < 4; i++) step();
        vectors++;
        if (ack !== 1'b0) begin $display("FAIL unstall_release: %b want 0", ack); miscompares++; end
    endtask

    task automatic test_protocol_err();
        dado = 2'd1; send = 1'b1;
        for (int i = 0; i < 4; i++) step();
        send = 1'b0;
        for (int i = 0; i < 4; i++) step();
        vectors += 4;
        if (proto_err !== 1'b1)  begin $display("FAIL perr_flag: %b want 1", proto_err); miscompares++; end
        if (rx_count !== 8'd6)   begin $display("FAIL perr_rx: %0d want 6", rx_count); miscompares++; end
        if (fifo_count !== 3'd4) begin $display("FAIL perr_count: %0d want 4", fifo_count); miscompares++; end
        if (ack !== 1'b0)        begin $display("FAIL perr_ack: %b want 0", ack); miscompares++; end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        step();
        vectors += 2;
        if (fifo_count !== 3'd0) begin $display("FAIL perr_drain: %0d want 0", fifo_count); miscompares++; end
        if (proto_err !== 1'b1)  begin $display("FAIL perr_sticky: %b want 1", proto_err); miscompares++; end
    endtask

    task automatic test_push_pop();
        xfer(2'd1); xfer(2'd2);
        dado = 2'd3; send = 1'b1;
        step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors += 4;
        if (ack !== 1'b1)        begin $display("FAIL pushpop_ack: %b want 1", ack); miscompares++; end
        if (fifo_count !== 3'd2) begin $display("FAIL pushpop_count: %0d want 2", fifo_count); miscompares++; end
        if (out_data !== 2'd2)   begin $display("FAIL pushpop_head: %0d want 2", out_data); miscompares++; end
        if (rx_count !== 8'd9)   begin $display("FAIL pushpop_rx: %0d want 9", rx_count); miscompares++; end
        send = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    // Randomized sender and consumer, every output compared against the model each cycle.
    task automatic test_random(input int n, input int ready_pct);
        int done = 0;
        int cyc  = 0;
        int budget = n * 40 + 50;
        while ((done < n || ack === 1'b1 || send === 1'b1) && cyc < budget) begin
            if (!send && ack === 1'b0 && done < n && $urandom_range(0, 3) != 0) begin
                dado = DATA_W'($urandom); send = 1'b1;
            end else if (send && ack === 1'b1) begin
                send = 1'b0; done++;
            end
            out_ready = ($urandom_range(0, 99) < ready_pct);
            step(); cyc++;
            vectors += 5;
            if (ack !== m_ack) begin $display("FAIL rnd_ack: %b want %b cyc %0d", ack, m_ack, cyc); miscompares++; end
            if (fifo_count !== CW'(m_q.size())) begin
                $display("FAIL rnd_count: %0d want %0d cyc %0d", fifo_count, m_q.size(), cyc); miscompares++;
            end
            if (out_valid !== (m_q.size() != 0)) begin
                $display("FAIL rnd_valid: %b want %b cyc %0d", out_valid, m_q.size() != 0, cyc); miscompares++;
            end
            if (rx_count !== 8'(m_rx)) begin $display("FAIL rnd_rx: %0d want %0d cyc %0d", rx_count, m_rx, cyc); miscompares++; end
            if (proto_err !== m_err) begin $display("FAIL rnd_err: %b want %b", proto_err, m_err); miscompares++; end
            if (m_q.size() != 0) begin
                vectors++;
                if (out_data !== m_q[0]) begin $display("FAIL rnd_data: %0d want %0d cyc %0d", out_data, m_q[0], cyc); miscompares++; end
            end
        end
        out_ready = 1'b0;
        vectors++;
        if (done < n) begin $display("FAIL rnd_timeout: %0d of %0d transfers", done, n); miscompares++; end
    endtask

    task automatic test_reset_during_ack();
        int t = 0;
        dado = 2'd2; send = 1'b1;
        while (ack !== 1'b1 && t < 30) begin step(); t++; end
        vectors++;
        if (ack !== 1'b1) begin $display("FAIL rstack_setup: ack=%b want 1", ack); miscompares++; end
        rst = 1'b1; send = 1'b0;
        step();
        rst = 1'b0;
        vectors += 5;
        if (ack !== 1'b0)        begin $display("FAIL rstack_ack: %b want 0", ack); miscompares++; end
        if (fifo_count !== 3'd0) begin $display("FAIL rstack_count: %0d want 0", fifo_count); miscompares++; end
        if (rx_count !== 8'd0)   begin $display("FAIL rstack_rx: %0d want 0", rx_count); miscompares++; end
        if (proto_err !== 1'b0)  begin $display("FAIL rstack_err: %b want 0", proto_err); miscompares++; end
        if (out_valid !== 1'b0)  begin $display("FAIL rstack_valid: %b want 0", out_valid); miscompares++; end
        step();
        dado = 2'd1; send = 1'b1;
        step(); step(); step();
        vectors += 4;
        if (ack !== 1'b1)        begin $display("FAIL rstack_redo_ack: %b want 1", ack); miscompares++; end
        if (out_data !== 2'd1)   begin $display("FAIL rstack_redo_data: %0d want 1", out_data); miscompares++; end
        if (rx_count !== 8'd1)   begin $display("FAIL rstack_redo_rx: %0d want 1", rx_count); miscompares++; end
        if (fifo_count !== 3'd1) begin $display("FAIL rstack_redo_count: %0d want 1", fifo_count); miscompares++; end
        send = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1; step(); rst = 1'b0; step();
        test_random(256, 100);
        vectors++;
        if (rx_count !== 8'd0) begin $display("FAIL wrap_256: rx=%0d want 0", rx_count); miscompares++; end
        test_random(1, 100);
        vectors++;
        if (rx_count !== 8'd1) begin $display("FAIL wrap_257: rx=%0d want 1", rx_count); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_protocol_err();
        test_push_pop();
        test_random(8, 60);
        test_random(40, 40);
        test_reset_during_ack();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
